// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundle between N_REQ byte producers, the round-robin arbiter and the UART TX
// parallel port.
//   req_valid       producer -> arbiter  per-requester byte available
//   req_data        producer -> arbiter  byte of requester i at [8*i+7:8*i]
//   req_ready       arbiter  -> producer one-hot accept pulse
//   tx_p_data       arbiter  -> UART TX  byte to transmit
//   tx_p_data_valid arbiter  -> UART TX  one-cycle issue strobe
//   busy            UART TX  -> arbiter  transmitter busy
//   grant_id        arbiter  -> status   index of current owner
//   arb_busy        arbiter  -> status   arbiter not idle
//   timeout_err     arbiter  -> status   watchdog pulse
// Modports: slave = arbiter side, master = producers/UART/environment side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_ready;
   logic [7:0]         tx_p_data;
   logic               tx_p_data_valid;
   logic               busy;
   logic [IW-1:0]      grant_id;
   logic               arb_busy;
   logic               timeout_err;

   modport slave (
      input  req_valid, req_data, busy,
      output req_ready, tx_p_data, tx_p_data_valid, grant_id, arb_busy, timeout_err
   );

   modport master (
      output req_valid, req_data, busy,
      input  req_ready, tx_p_data, tx_p_data_valid, grant_id, arb_busy, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter between N_REQ producers.
// Accepts one byte from the winner, issues it as a one-cycle strobe, then
// follows the transmitter's busy rise and fall before arbitrating again.
// Ports:
//   CLK  transmitter clock
//   RST  synchronous active-high reset
//   bus  uart_tx_arbiter_if.slave (requester, UART TX and status signals)
// Optional feature: define UART_ARB_TIMEOUT_EN to build the WAIT_HI watchdog
// (8-bit counter, timeout_err pulse). Without it timeout_err is tied low and
// WAIT_HI waits indefinitely.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 8
) (
   input logic              CLK,
   input logic              RST,
   uart_tx_arbiter_if.slave bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT_HI = 2'd2;
   localparam logic [1:0] ST_WAIT_LO = 2'd3;

   // last points at the most recent owner; reset value makes requester 0 win first
   localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
      $error("uart_tx_arbiter: N_REQ or TIMEOUT out of range");
   end

   logic [1:0]       state_q, state_d;
   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    grant_id_q, grant_id_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic             arb_busy_q, arb_busy_d;
   logic [IW-1:0]    idx_s;
   logic [IW-1:0]    win_idx_s;
   logic             win_found_s;
   logic             grant_s;
   logic [N_REQ-1:0] req_ready_s;
   logic [7:0]       sel_data_s;
`ifdef UART_ARB_TIMEOUT_EN
   logic [7:0]       cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;
`endif

   // Round-robin search: first asserted request starting at last+1, wrapping
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      idx_s       = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx_s = IW'((int'(last_q) + k) % N_REQ);
         if (!win_found_s && bus.req_valid[idx_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = idx_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Accept decode and winner data mux; grants are suppressed while RST is high
   always_comb begin
      grant_s     = (state_q == ST_IDLE) && !bus.busy && win_found_s && !RST;
      req_ready_s = '0;
      sel_data_s  = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx_s == IW'(i)) begin
            req_ready_s[i] = grant_s;
            sel_data_s     = bus.req_data[8*i +: 8];
         end else begin
            req_ready_s[i] = 1'b0;
         end
      end
   end

   // FSM next-state and registered-output next values
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_id_d = grant_id_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_err_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_s) begin
               state_d    = ST_ISSUE;
               last_d     = win_idx_s;
               grant_id_d = win_idx_s;
               tx_data_d  = sel_data_s;
               tx_valid_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_HI;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
         end
         ST_WAIT_HI: begin
`ifdef UART_ARB_TIMEOUT_EN
            if (bus.busy) begin
               state_d = ST_WAIT_LO;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               // last keeps the timed-out owner so others go first next time
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`else
            if (bus.busy) begin
               state_d = ST_WAIT_LO;
            end else begin
               state_d = ST_WAIT_HI;
            end
`endif
         end
         ST_WAIT_LO: begin
            if (!bus.busy) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_LO;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      arb_busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         last_q     <= LAST_RST;
         grant_id_q <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         arb_busy_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q         <= 8'd0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_id_q <= grant_id_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         arb_busy_q <= arb_busy_d;
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign bus.req_ready       = req_ready_s;
   assign bus.tx_p_data       = tx_data_q;
   assign bus.tx_p_data_valid = tx_valid_q;
   assign bus.grant_id        = grant_id_q;
   assign bus.arb_busy        = arb_busy_q;
`ifdef UART_ARB_TIMEOUT_EN
   assign bus.timeout_err     = timeout_err_q;
`else
   assign bus.timeout_err     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=8). A cycle table covers the
// single-request and busy-already-high cases; hand sequences cover round-robin
// order, fairness, the watchdog (UART_ARB_TIMEOUT_EN on or off) and reset
// mid-frame. A negedge monitor pushes each accepted byte onto a scoreboard and
// pops it when the issue strobe appears.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int bcnt   = 0;
   int busy_len = 0;

   logic [7:0] tb_data [N];
   assign bus.req_data = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
      int         acc_cyc;
   } sb_t;
   sb_t sb_q [$];
   sb_t mon_e;
   int  grant_log [$];
   int  grant_cyc [$];

   typedef struct packed {
      logic [3:0] valid;
      logic       busy;
      logic [3:0] exp_ready;
      logic       exp_txv;
      logic       exp_arb;
   } vec_t;
   vec_t vecs [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.req_ready != 4'b0000) begin
            chk("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
            chk("ready_without_valid", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
            for (int i = 0; i < N; i++) begin
               if (bus.req_ready[i]) begin
                  sb_q.push_back('{id: 2'(i), data: tb_data[i], acc_cyc: cyc});
                  grant_log.push_back(i);
                  grant_cyc.push_back(cyc);
               end
            end
         end
         if (bus.arb_busy) chk("ready_outside_idle", 32'(bus.req_ready), 32'd0);
         if (bus.tx_p_data_valid) begin
            if (sb_q.size() == 0) begin
               chk("issue_without_accept", 32'd1, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("issue_data", 32'(bus.tx_p_data), 32'(mon_e.data));
               chk("issue_grant_id", 32'(bus.grant_id), 32'(mon_e.id));
               chk("issue_latency", 32'(cyc), 32'(mon_e.acc_cyc + 1));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle with a UART busy model: busy rises the cycle after the strobe
   task automatic cycle_model();
      tick();
      bus.busy = (bcnt > 0);
      if (bcnt > 0) bcnt--;
      if (bus.tx_p_data_valid) bcnt = busy_len;
   endtask

   task automatic run_until(input int n, input string name);
      int k = 0;
      while (grant_log.size() < n && k < 300) begin
         cycle_model();
         k++;
      end
      chk({name, "_grant_wait"}, 32'(grant_log.size() >= n), 32'd1);
   endtask

   task automatic drain(input string name);
      int k = 0;
      while ((bus.arb_busy || bcnt > 0 || bus.busy) && k < 300) begin
         cycle_model();
         k++;
      end
      chk({name, "_drain"}, 32'(bus.arb_busy), 32'd0);
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_tx_p_data"}, 32'(bus.tx_p_data), 32'd0);
      chk({name, "_tx_valid"}, 32'(bus.tx_p_data_valid), 32'd0);
      chk({name, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      chk({name, "_grant_id"}, 32'(bus.grant_id), 32'd0);
      chk({name, "_arb_busy"}, 32'(bus.arb_busy), 32'd0);
      chk({name, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = 4'b0000;
      bus.busy = 1'b0;
      bcnt = 0;
      tick();
      tick();
      sb_q.delete();
      grant_log.delete();
      grant_cyc.delete();
      rst = 1'b0;
   endtask

   task automatic check_log(input string name, input int exp [$]);
      chk({name, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
         chk($sformatf("%s_order%0d", name, i), 32'(grant_log[i]), 32'(exp[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int n_err;
      int err_cyc;
      int arb_low;
      int a_cyc;

      tb_data[0] = 8'h11;
      tb_data[1] = 8'h22;
      tb_data[2] = 8'hA5;
      tb_data[3] = 8'h44;
      bus.req_valid = 4'b0000;
      bus.busy = 1'b0;

      // Single request: accept, issue, 10 busy cycles, next accept after fall
      vecs.push_back('{4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0});
      vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1});
      vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1});
      for (int i = 0; i < 9; i++) vecs.push_back('{4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1});
      vecs.push_back('{4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1});
      vecs.push_back('{4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0});
      vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1});
      vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1});
      vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1});
      // Busy already high in IDLE, then busy high during ISSUE
      for (int i = 0; i < 3; i++) vecs.push_back('{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0});
      vecs.push_back('{4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0});
      vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1});
      vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1});
      vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1});
      vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0});

      do_reset();
      #1;
      check_idle_outputs("reset");

      for (int r = 0; r < vecs.size(); r++) begin
         tick();
         bus.req_valid = vecs[r].valid;
         bus.busy = vecs[r].busy;
         #1;
         chk($sformatf("vec%0d_ready", r), 32'(bus.req_ready), 32'(vecs[r].exp_ready));
         chk($sformatf("vec%0d_txv", r), 32'(bus.tx_p_data_valid), 32'(vecs[r].exp_txv));
         chk($sformatf("vec%0d_arb", r), 32'(bus.arb_busy), 32'(vecs[r].exp_arb));
      end
      check_log("table", '{2, 2, 0});
      chk("tx_data_hold", 32'(bus.tx_p_data), 32'h11);

      // Simultaneous requests: round-robin 0,1,2,3,0
      do_reset();
      busy_len = 3;
      bus.req_valid = 4'b1111;
      run_until(5, "rr");
      bus.req_valid = 4'b0000;
      drain("rr");
      check_log("rr", '{0, 1, 2, 3, 0});
      chk("rr_sb_empty", 32'(sb_q.size()), 32'd0);

      // Fairness: 1 held, 3 requests once -> 1,3,1
      do_reset();
      bus.req_valid = 4'b0010;
      run_until(1, "fair1");
      bus.req_valid = 4'b1010;
      run_until(2, "fair2");
      bus.req_valid = 4'b0010;
      run_until(3, "fair3");
      bus.req_valid = 4'b0000;
      drain("fair");
      check_log("fair", '{1, 3, 1});

      // Watchdog: busy never rises after the issue
      do_reset();
      busy_len = 0;
      bus.req_valid = 4'b0001;
      run_until(1, "wd");
      bus.req_valid = 4'b0000;
      a_cyc = (grant_cyc.size() > 0) ? grant_cyc[0] : 0;
      n_err = 0;
      err_cyc = 0;
      arb_low = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.timeout_err) begin
            n_err++;
            err_cyc = cyc;
         end
         if (!bus.arb_busy) arb_low++;
      end
`ifdef UART_ARB_TIMEOUT_EN
      chk("wd_err_pulses", 32'(n_err), 32'd1);
      chk("wd_err_cycle", 32'(err_cyc), 32'(a_cyc + 10));
      chk("wd_back_idle", 32'(bus.arb_busy), 32'd0);
      chk("wd_no_regrant", 32'(grant_log.size()), 32'd1);
`else
      chk("wd_err_pulses", 32'(n_err), 32'd0);
      chk("wd_stays_wait_hi", 32'(arb_low), 32'd0);
      bus.busy = 1'b1;
      tick();
      bus.busy = 1'b0;
      tick();
      tick();
      chk("wd_recover_idle", 32'(bus.arb_busy), 32'd0);
`endif

      // Reset during WAIT_LO, then priority restarts from requester 0
      do_reset();
      busy_len = 10;
      bus.req_valid = 4'b0100;
      run_until(1, "mid");
      bus.req_valid = 4'b0000;
      cycle_model();
      cycle_model();
      chk("mid_in_wait_lo", 32'({bus.arb_busy, bus.busy}), 32'd3);
      rst = 1'b1;
      tick();
      check_idle_outputs("mid_reset");
      chk("mid_sb_empty", 32'(sb_q.size()), 32'd0);
      rst = 1'b0;
      bus.busy = 1'b0;
      bcnt = 0;
      busy_len = 3;
      grant_log.delete();
      grant_cyc.delete();
      bus.req_valid = 4'b1000;
      run_until(1, "post1");
      bus.req_valid = 4'b0011;
      run_until(2, "post2");
      bus.req_valid = 4'b0000;
      drain("post");
      check_log("post", '{3, 0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
